requantize_pipeline: RTL

REQUANTIZE_PIPELINE -- requirements
Module: requantize_pipeline

---
 rtl/requantize_pipeline_if.sv | 31 +++
 rtl/requantize_pipeline.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/requantize_pipeline_if.sv
// Valid/ready bundle for the requantizer: one input beat of per-lane accumulators
// and scales in, one beat of int8 results with per-lane saturation flags out.
interface requantize_pipeline_if #(
    parameter int LANES   = 4,
    parameter int SHIFT_W = 6
);
    logic                             in_valid;
    logic                             in_ready;
    logic [LANES-1:0][31:0]           acc;
    logic [LANES-1:0][31:0]           quant_mult;
    logic [LANES-1:0][SHIFT_W-1:0]    shift;
    logic [7:0]                       zero_point;
    logic [7:0]                       act_min;
    logic [7:0]                       act_max;
    logic                             out_valid;
    logic                             out_ready;
    logic [LANES-1:0][7:0]            out_data;
    logic [LANES-1:0]                 sat_flags;

    // The beat source / result sink side.
    modport master (
        output in_valid, acc, quant_mult, shift, zero_point, act_min, act_max, out_ready,
        input  in_ready, out_valid, out_data, sat_flags
    );

    // The requantizer side.
    modport slave (
        input  in_valid, acc, quant_mult, shift, zero_point, act_min, act_max, out_ready,
        output in_ready, out_valid, out_data, sat_flags
    );
endinterface

// File: rtl/requantize_pipeline.sv
// Per-channel int32 -> int8 requantizer: Q31 multiply, rounding high half, rounding
// shift, zero-point offset and activation clamp, with elastic valid/ready flow control.
module requantize_pipeline #(
    parameter int LANES   = 4,
    parameter int SHIFT_W = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    requantize_pipeline_if.slave bus
);

    localparam logic signed [63:0] RND_HALF_Q31 = 64'sh0000_0000_4000_0000;
    localparam logic signed [63:0] PROD_MIN_SQ  = 64'sh4000_0000_0000_0000;
    localparam logic signed [63:0] INT32_MAX_W  = 64'sh0000_0000_7FFF_FFFF;
    localparam logic signed [63:0] INT32_MIN_W  = 64'shFFFF_FFFF_8000_0000;

    function automatic logic signed [63:0] f_sext32(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

    // Only (-2^31)*(-2^31) yields 2^62, so the overflow corner is detected on the product.
    function automatic logic [31:0] f_round_hi(input logic [63:0] prod);
        logic signed [63:0] sum_v;
        logic [31:0]        hi_v;
        if (prod == PROD_MIN_SQ) begin
            hi_v = 32'h7FFF_FFFF;
        end else begin
            sum_v = ($signed(prod) + RND_HALF_Q31) >>> 5'd31;
            hi_v  = sum_v[31:0];
        end
        return hi_v;
    endfunction

    // Returns {sat, q}: rounding right shift or saturating left shift, offset, clamp.
    function automatic logic [8:0] f_scale_lane(
        input logic signed [31:0]        hi,
        input logic signed [SHIFT_W-1:0] sh,
        input logic signed [7:0]         zp,
        input logic signed [7:0]         lo_bound,
        input logic signed [7:0]         hi_bound
    );
        int                 sh_i;
        int                 amt;
        logic signed [63:0] wide_v;
        logic signed [31:0] r_v;
        logic signed [32:0] v_v;
        logic signed [32:0] min_v;
        logic signed [32:0] max_v;
        logic               sat_v;
        logic [7:0]         q_v;
        sh_i   = int'(sh);
        wide_v = f_sext32(hi);
        if (sh_i > 32'sd0) begin
            amt    = (sh_i > 32'sd31) ? 32'sd31 : sh_i;
            wide_v = (wide_v + (64'sd1 <<< (amt - 32'sd1))) >>> amt;
            r_v    = wide_v[31:0];
            sat_v  = 1'b0;
        end else begin
            amt    = (-sh_i > 32'sd31) ? 32'sd31 : -sh_i;
            wide_v = wide_v <<< amt;
            if (wide_v > INT32_MAX_W) begin
                r_v   = 32'sh7FFF_FFFF;
                sat_v = 1'b1;
            end else if (wide_v < INT32_MIN_W) begin
                r_v   = 32'sh8000_0000;
                sat_v = 1'b1;
            end else begin
                r_v   = wide_v[31:0];
                sat_v = 1'b0;
            end
        end
        v_v   = {r_v[31], r_v} + {{25{zp[7]}}, zp};
        min_v = {{25{lo_bound[7]}}, lo_bound};
        max_v = {{25{hi_bound[7]}}, hi_bound};
        if (v_v < min_v) begin
            q_v   = lo_bound;
            sat_v = 1'b1;
        end else if (v_v > max_v) begin
            q_v   = hi_bound;
            sat_v = 1'b1;
        end else begin
            q_v = v_v[7:0];
        end
        return {sat_v, q_v};
    endfunction

    logic                          s1_valid_r;
    logic                          s2_valid_r;
    logic                          s3_valid_r;
    logic                          out_valid_r;
    logic                          ld1_s;
    logic                          ld2_s;
    logic                          ld3_s;
    logic                          ld_out_s;

    logic [LANES-1:0][31:0]        s1_acc_r;
    logic [LANES-1:0][31:0]        s1_mult_r;
    logic [LANES-1:0][SHIFT_W-1:0] s1_shift_r;
    logic [7:0]                    s1_zp_r;
    logic [7:0]                    s1_min_r;
    logic [7:0]                    s1_max_r;

    logic [LANES-1:0][63:0]        s2_prod_r;
    logic [LANES-1:0][SHIFT_W-1:0] s2_shift_r;
    logic [7:0]                    s2_zp_r;
    logic [7:0]                    s2_min_r;
    logic [7:0]                    s2_max_r;

    logic [LANES-1:0][31:0]        s3_hi_r;
    logic [LANES-1:0][SHIFT_W-1:0] s3_shift_r;
    logic [7:0]                    s3_zp_r;
    logic [7:0]                    s3_min_r;
    logic [7:0]                    s3_max_r;

    logic [LANES-1:0][7:0]         out_data_r;
    logic [LANES-1:0]              sat_r;

    logic [LANES-1:0][63:0]        prod_s;
    logic [LANES-1:0][31:0]        hi_s;
    logic [LANES-1:0][8:0]         res_s;

    // Load-enable chain: a register loads when it is empty or its successor loads,
    // which collapses bubbles and sustains one beat per cycle.
    always_comb begin
        ld_out_s = ~out_valid_r | bus.out_ready;
        ld3_s    = ~s3_valid_r | ld_out_s;
        ld2_s    = ~s2_valid_r | ld3_s;
        ld1_s    = ~s1_valid_r | ld2_s;
    end

    // Per-lane arithmetic between the pipeline registers.
    always_comb begin
        for (int i = 32'sd0; i < LANES; i++) begin
            prod_s[i] = f_sext32(s1_acc_r[i]) * f_sext32(s1_mult_r[i]);
            hi_s[i]   = f_round_hi(s2_prod_r[i]);
            res_s[i]  = f_scale_lane(s3_hi_r[i], s3_shift_r[i], s3_zp_r, s3_min_r, s3_max_r);
        end
    end

    // Occupancy bits; cleared asynchronously so every in-flight beat is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_r  <= 1'b0;
            s2_valid_r  <= 1'b0;
            s3_valid_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            if (ld1_s)    s1_valid_r  <= bus.in_valid;
            if (ld2_s)    s2_valid_r  <= s1_valid_r;
            if (ld3_s)    s3_valid_r  <= s2_valid_r;
            if (ld_out_s) out_valid_r <= s3_valid_r;
        end
    end

    // S1 operand capture; zero point and clamp bounds ride along with their beat.
    always_ff @(posedge clk) begin
        if (ld1_s && bus.in_valid) begin
            s1_acc_r   <= bus.acc;
            s1_mult_r  <= bus.quant_mult;
            s1_shift_r <= bus.shift;
            s1_zp_r    <= bus.zero_point;
            s1_min_r   <= bus.act_min;
            s1_max_r   <= bus.act_max;
        end
    end

    // S2 full-width product.
    always_ff @(posedge clk) begin
        if (ld2_s && s1_valid_r) begin
            s2_prod_r  <= prod_s;
            s2_shift_r <= s1_shift_r;
            s2_zp_r    <= s1_zp_r;
            s2_min_r   <= s1_min_r;
            s2_max_r   <= s1_max_r;
        end
    end

    // S3 rounded high half.
    always_ff @(posedge clk) begin
        if (ld3_s && s2_valid_r) begin
            s3_hi_r    <= hi_s;
            s3_shift_r <= s2_shift_r;
            s3_zp_r    <= s2_zp_r;
            s3_min_r   <= s2_min_r;
            s3_max_r   <= s2_max_r;
        end
    end

    // Output register: reset to zero, then only ever loaded with a real beat so it
    // holds steady while the sink stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data_r <= '0;
            sat_r      <= '0;
        end else if (ld_out_s && s3_valid_r) begin
            for (int i = 32'sd0; i < LANES; i++) begin
                out_data_r[i] <= res_s[i][7:0];
                sat_r[i]      <= res_s[i][8];
            end
        end
    end

    assign bus.in_ready  = ld1_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.sat_flags = sat_r;

endmodule
